uart_transceiver: RTL and testbench
===================================

// Module: uart_transceiver
// PURPOSE
//  Parametrised full-duplex UART: TX serialiser plus oversampling RX deserialiser sharing one baud tick generator.
//  Supports configurable data width, parity and stop bits, and reports parity/framing errors.
//  Sits between the on-chip byte interface and the board txd/rxd pins.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock, Hz
//  BAUD        115_200     line rate, bit/s
//  OVERSAMPLE  16          RX samples per bit, even, >=8
//  DATA_BITS   8           payload bits per frame, 5..9
//  PARITY      0           0 none, 1 even, 2 odd
//  STOP_BITS   1           1 or 2, TX only; RX checks first stop bit only
// PORTS
//  clk            in   1          system clock, rising edge
//  rst_n          in   1          asynchronous active-low reset
//  tx_start       in   1          request to send tx_data
//  tx_data        in   DATA_BITS  payload, sampled on acceptance
//  tx_busy        out  1          frame in progress
//  txd            out  1          serial out, idle high
//  rxd            in   1          serial in, asynchronous to clk
//  rx_valid       out  1          one-cycle pulse, new word in rx_data
//  rx_data        out  DATA_BITS  received payload, LSB first on line
//  rx_parity_err  out  1          parity mismatch for last word
//  rx_frame_err   out  1          stop bit sampled low for last word
//  loopback       in   1          internal loopback select (UART_LOOPBACK_EN only)
// BEHAVIOUR
//  Reset: txd=1, tx_busy=0, rx_valid=0, rx_data=0, rx_parity_err=0, rx_frame_err=0; both FSMs IDLE; sync regs=1.
//  Tick: free-running counter, DIV=CLK_FREQ/(BAUD*OVERSAMPLE) (integer, min 1); one-cycle tick every DIV clocks.
//  TX FSM IDLE->START->DATA->PARITY(if PARITY!=0)->STOP->IDLE; each bit lasts OVERSAMPLE ticks.
//   - tx_start accepted only when tx_busy=0; tx_data latched; tx_busy=1 and txd=0 from next cycle.
//   - tx_start while busy ignored (no queueing). Held high: next frame accepted the cycle busy falls.
//   - Data LSB first; parity bit = XOR(data) for even, ~XOR(data) for odd.
//   - tx_busy falls the cycle after last stop bit's final tick; txd stays 1.
//  RX path: rxd through 2-flop synchroniser; falling edge in IDLE starts RX FSM, sample counter cleared.
//   - START: at sample OVERSAMPLE/2 line must be 0, else glitch -> IDLE with no output.
//   - DATA/PARITY/STOP: each bit = 2-of-3 majority of samples OVERSAMPLE/2-1..OVERSAMPLE/2+1.
//   - At mid stop bit: rx_valid=1 for one cycle; rx_data, rx_parity_err, rx_frame_err updated same cycle.
//   - Word delivered even with errors; error flags held until next rx_valid.
//   - After rx_valid: stop=1 -> IDLE immediately (resync on next edge); stop=0 (break) -> wait rxd=1 first.
//   - Latency: rx_valid ~ (1+DATA_BITS+P+0.5) bit periods + 2 clk sync after start edge.
//  TX and RX fully independent; simultaneous activity allowed.
//  rst_n low mid-frame: both FSMs abort at once, outputs to reset values, no rx_valid.
// CONFIGURATION
//  UART_LOOPBACK_EN defined: loopback=1 feeds internal txd to RX synchroniser input, rxd ignored;
//   pin txd is forced 1 while loopback=1. Switching loopback mid-frame is undefined.
//  UART_LOOPBACK_EN undefined: loopback port present but ignored; RX always from rxd, txd always driven by TX.
// TESTING  (bench: CLK_FREQ=1_600_000, BAUD=100_000, OVERSAMPLE=16 -> 1 bit=16 clk)
//  Reset: rst_n=0 mid-TX of 0x58 -> txd=1, tx_busy=0 within same edge; no rx_valid after release.
//  8N1: txd wired to rxd, send 0x58 -> txd pattern 0,0,0,0,1,1,0,1,0,1 (16 clk each); tx_busy 160 clk; rx_valid, rx_data=0x58, errs=0.
//  Even parity: send 0x07 -> parity bit 1 on line; rxd-driven frame with parity 0 -> rx_parity_err=1, rx_data=0x07.
//  Framing: drive 0xA5 with stop bit 0 -> rx_valid, rx_frame_err=1; RX not rearmed until rxd returns 1.
//  Glitch: 4-clk low pulse on idle rxd -> no rx_valid; next valid 0x3C frame received correctly.
//  Back-to-back: tx_start held high, data 0x11 then 0x22 -> no idle gap, both received; with UART_LOOPBACK_EN and loopback=1 pin txd stays 1 and 0x11 still received.

Source files
------------

// File: rtl/uart_transceiver.sv
// Full-duplex UART: TX serialiser and oversampling RX deserialiser driven by one shared baud tick.
// Optional feature: define UART_LOOPBACK_EN to route the internal TX line into the RX path when loopback=1.
module uart_transceiver #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 txd,
  input  logic                 rxd,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  input  logic                 loopback
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = $clog2(DIV + 1);
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int MID     = OVERSAMPLE / 2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  tx_state_t              tx_state, tx_state_n;
  logic [DATA_BITS-1:0]   tx_shift, tx_shift_n;
  logic                   tx_par, tx_par_n;
  logic [OS_W-1:0]        tx_tick_cnt, tx_tick_n;
  logic [3:0]             tx_bit_cnt, tx_bit_n;
  logic                   tx_bit_end;
  logic                   tx_line;

  rx_state_t              rx_state, rx_state_n;
  logic                   rx_sync1, rx_sync2, rx_prev;
  logic                   rx_line;
  logic [OS_W-1:0]        rx_samp_cnt, rx_samp_n;
  logic [3:0]             rx_bit_cnt, rx_bit_n;
  logic [1:0]             rx_votes, rx_votes_n;
  logic [DATA_BITS-1:0]   rx_shift, rx_shift_n;
  logic                   rx_par_bit, rx_par_bit_n;
  logic                   rx_valid_n, rx_perr_n, rx_ferr_n;
  logic [DATA_BITS-1:0]   rx_data_n;
  logic                   rx_fall, samp_lo, samp_mid, samp_hi, rx_bit_end, rx_maj;

`ifdef UART_LOOPBACK_EN
  assign rx_line = loopback ? tx_line : rxd;
  assign txd     = loopback ? 1'b1 : tx_line;
`else
  logic unused_loopback;
  assign unused_loopback = loopback;
  assign rx_line = rxd;
  assign txd     = tx_line;
`endif

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  // Handshake: tx_start is a request that is taken only in a cycle where tx_busy=0;
  // tx_data is captured in that cycle and tx_busy stays high until the frame is out.
  assign tx_busy    = (tx_state != TX_IDLE);
  assign tx_bit_end = tick && (tx_tick_cnt == OS_W'(OVERSAMPLE - 1));

  always_comb begin
    tx_state_n = tx_state;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_bit_n   = tx_bit_cnt;
    tx_tick_n  = tx_bit_end ? '0 : (tick ? tx_tick_cnt + OS_W'(1) : tx_tick_cnt);
    tx_line    = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_tick_n = '0;
        tx_bit_n  = '0;
        if (tx_start) begin
          tx_state_n = TX_START;
          tx_shift_n = tx_data;
          tx_par_n   = (PARITY == 2) ? ~(^tx_data) : ^tx_data;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_bit_end) begin
          tx_shift_n = tx_shift >> 1;
          if (tx_bit_cnt == 4'(DATA_BITS - 1)) begin
            tx_bit_n   = '0;
            tx_state_n = (PARITY != 0) ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_n = tx_bit_cnt + 4'd1;
          end
        end
      end
      TX_PARITY: begin
        tx_line = tx_par;
        if (tx_bit_end) tx_state_n = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_bit_cnt == 4'(STOP_BITS - 1)) tx_state_n = TX_IDLE;
          else tx_bit_n = tx_bit_cnt + 4'd1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // Samples are taken on ticks counted from the synchronised start edge.
  assign rx_fall    = rx_prev & ~rx_sync2;
  assign samp_lo    = tick && (rx_samp_cnt == OS_W'(MID - 1));
  assign samp_mid   = tick && (rx_samp_cnt == OS_W'(MID));
  assign samp_hi    = tick && (rx_samp_cnt == OS_W'(MID + 1));
  assign rx_bit_end = tick && (rx_samp_cnt == OS_W'(OVERSAMPLE - 1));
  assign rx_maj     = (rx_votes[0] & rx_votes[1]) | (rx_votes[0] & rx_sync2) |
                      (rx_votes[1] & rx_sync2);

  always_comb begin
    rx_state_n   = rx_state;
    rx_samp_n    = rx_bit_end ? '0 : (tick ? rx_samp_cnt + OS_W'(1) : rx_samp_cnt);
    rx_bit_n     = rx_bit_cnt;
    rx_votes_n   = rx_votes;
    rx_shift_n   = rx_shift;
    rx_par_bit_n = rx_par_bit;
    rx_valid_n   = 1'b0;
    rx_data_n    = rx_data;
    rx_perr_n    = rx_parity_err;
    rx_ferr_n    = rx_frame_err;
    if (samp_lo)  rx_votes_n[0] = rx_sync2;
    if (samp_mid) rx_votes_n[1] = rx_sync2;
    case (rx_state)
      RX_IDLE: begin
        rx_samp_n = '0;
        rx_bit_n  = '0;
        if (rx_fall) rx_state_n = RX_START;
      end
      RX_START: begin
        if (samp_mid && rx_sync2) rx_state_n = RX_IDLE;
        else if (rx_bit_end)      rx_state_n = RX_DATA;
      end
      RX_DATA: begin
        if (samp_hi) rx_shift_n = {rx_maj, rx_shift[DATA_BITS-1:1]};
        if (rx_bit_end) begin
          if (rx_bit_cnt == 4'(DATA_BITS - 1)) begin
            rx_bit_n   = '0;
            rx_state_n = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_n = rx_bit_cnt + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (samp_hi)    rx_par_bit_n = rx_maj;
        if (rx_bit_end) rx_state_n   = RX_STOP;
      end
      RX_STOP: begin
        if (samp_hi) begin
          rx_valid_n = 1'b1;
          rx_data_n  = rx_shift;
          rx_perr_n  = (PARITY != 0) && (rx_par_bit ^ (^rx_shift) ^ (PARITY == 2));
          rx_ferr_n  = ~rx_maj;
          rx_state_n = rx_maj ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        rx_samp_n = '0;
        if (rx_sync2) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt       <= '0;
      tx_state      <= TX_IDLE;
      tx_shift      <= '0;
      tx_par        <= 1'b0;
      tx_tick_cnt   <= '0;
      tx_bit_cnt    <= '0;
      rx_sync1      <= 1'b1;
      rx_sync2      <= 1'b1;
      rx_prev       <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_samp_cnt   <= '0;
      rx_bit_cnt    <= '0;
      rx_votes      <= '0;
      rx_shift      <= '0;
      rx_par_bit    <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      div_cnt       <= tick ? '0 : div_cnt + DIV_W'(1);
      tx_state      <= tx_state_n;
      tx_shift      <= tx_shift_n;
      tx_par        <= tx_par_n;
      tx_tick_cnt   <= tx_tick_n;
      tx_bit_cnt    <= tx_bit_n;
      rx_sync1      <= rx_line;
      rx_sync2      <= rx_sync1;
      rx_prev       <= rx_sync2;
      rx_state      <= rx_state_n;
      rx_samp_cnt   <= rx_samp_n;
      rx_bit_cnt    <= rx_bit_n;
      rx_votes      <= rx_votes_n;
      rx_shift      <= rx_shift_n;
      rx_par_bit    <= rx_par_bit_n;
      rx_valid      <= rx_valid_n;
      rx_data       <= rx_data_n;
      rx_parity_err <= rx_perr_n;
      rx_frame_err  <= rx_ferr_n;
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: one 8N1 instance and one 8E1 instance, 16 clocks per bit.
// Expected RX words go into per-instance queues; a negedge monitor pops and compares on rx_valid.
module tb_uart_transceiver;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int BIT_CLK  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          tx_start1, tx_start2;
  logic [DB-1:0] tx_data1, tx_data2;
  logic          tx_busy1, tx_busy2, txd1, txd2;
  logic          rxd1, rxd2;
  logic          rx_valid1, rx_valid2;
  logic [DB-1:0] rx_data1, rx_data2;
  logic          perr1, perr2, ferr1, ferr2;
  logic          loopback1, loopback2;
  logic          drv_rxd, sel1, sel2;

  assign rxd1 = sel1 ? drv_rxd : txd1;
  assign rxd2 = sel2 ? drv_rxd : txd2;

  uart_transceiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(DB),
                     .PARITY(0), .STOP_BITS(1)) u_dut_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start1), .tx_data(tx_data1), .tx_busy(tx_busy1),
    .txd(txd1), .rxd(rxd1), .rx_valid(rx_valid1), .rx_data(rx_data1),
    .rx_parity_err(perr1), .rx_frame_err(ferr1), .loopback(loopback1));

  uart_transceiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(DB),
                     .PARITY(1), .STOP_BITS(1)) u_dut_8e1 (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start2), .tx_data(tx_data2), .tx_busy(tx_busy2),
    .txd(txd2), .rxd(rxd2), .rx_valid(rx_valid2), .rx_data(rx_data2),
    .rx_parity_err(perr2), .rx_frame_err(ferr2), .loopback(loopback2));

  int checks   = 0;
  int failures = 0;

  // Queue entries are {frame_err, parity_err, data}.
  logic [DB+1:0] exp_q1[$];
  logic [DB+1:0] exp_q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rx_valid1) begin
      if (exp_q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx1_unexpected actual=0x%0h required=no_word", {ferr1, perr1, rx_data1});
      end else begin
        check("rx1_word", 32'({ferr1, perr1, rx_data1}), 32'(exp_q1.pop_front()));
      end
    end
    if (rx_valid2) begin
      if (exp_q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx2_unexpected actual=0x%0h required=no_word", {ferr2, perr2, rx_data2});
      end else begin
        check("rx2_word", 32'({ferr2, perr2, rx_data2}), 32'(exp_q2.pop_front()));
      end
    end
  end

  // Sends one frame and checks txd at the middle of each bit plus the busy length.
  task automatic tx_send(input int which, input logic [DB-1:0] d, input logic [15:0] pat,
                         input int nbits, input int exp_busy, input string name);
    int busy_cnt;
    logic b, t;
    busy_cnt = 0;
    @(negedge clk);
    if (which == 1) begin tx_start1 = 1'b1; tx_data1 = d; end
    else            begin tx_start2 = 1'b1; tx_data2 = d; end
    @(posedge clk);
    #1;
    tx_start1 = 1'b0;
    tx_start2 = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      b = (which == 1) ? tx_busy1 : tx_busy2;
      t = (which == 1) ? txd1 : txd2;
      if ((k % BIT_CLK) == 7 && (k / BIT_CLK) < nbits)
        check({name, "_txd_bit"}, 32'(t), 32'(pat[k / BIT_CLK]));
      if (!b) begin
        check({name, "_txd_idle"}, 32'(t), 32'd1);
        break;
      end
      busy_cnt++;
    end
    check({name, "_busy_len"}, 32'(busy_cnt), 32'(exp_busy));
  endtask

  task automatic drive_frame(input logic [DB-1:0] d, input bit use_par, input logic par,
                             input logic stop);
    @(negedge clk);
    drv_rxd = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      drv_rxd = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (use_par) begin
      drv_rxd = par;
      repeat (BIT_CLK) @(negedge clk);
    end
    drv_rxd = stop;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic wait_drain(input int which, input string name);
    int n;
    n = 0;
    while (((which == 1) ? exp_q1.size() : exp_q2.size()) != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, 32'((which == 1) ? exp_q1.size() : exp_q2.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    rst_n     = 1'b0;
    tx_start1 = 1'b0; tx_start2 = 1'b0;
    tx_data1  = '0;   tx_data2  = '0;
    loopback1 = 1'b0; loopback2 = 1'b0;
    drv_rxd   = 1'b1; sel1 = 1'b0; sel2 = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_txd1", 32'(txd1), 32'd1);
    check("rst_busy1", 32'(tx_busy1), 32'd0);
    check("rst_rx1", 32'({rx_valid1, ferr1, perr1, rx_data1}), 32'd0);
    check("rst_txd2", 32'(txd2), 32'd1);
    check("rst_rx2", 32'({rx_valid2, ferr2, perr2, rx_data2}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset mid-frame: abort at once, no word afterwards
    tx_start1 = 1'b1; tx_data1 = 8'h58;
    @(negedge clk);
    tx_start1 = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_rst_busy", 32'(tx_busy1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_txd", 32'(txd1), 32'd1);
    check("midrst_busy", 32'(tx_busy1), 32'd0);
    check("midrst_rx", 32'({rx_valid1, ferr1, perr1, rx_data1}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);

    // 8N1 wired loop 0x58
    exp_q1.push_back({1'b0, 1'b0, 8'h58});
    tx_send(1, 8'h58, 16'h02B0, 10, 160, "n1_58");
    wait_drain(1, "n1_58");

    // Even parity 0x07 wired loop, then a driven frame with a wrong parity bit
    exp_q2.push_back({1'b0, 1'b0, 8'h07});
    tx_send(2, 8'h07, 16'h060E, 11, 176, "e1_07");
    wait_drain(2, "e1_07");
    sel2 = 1'b1;
    exp_q2.push_back({1'b0, 1'b1, 8'h07});
    drive_frame(8'h07, 1'b1, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    wait_drain(2, "e1_perr");
    sel2 = 1'b0;

    // Framing error with a held break, then release
    sel1 = 1'b1;
    exp_q1.push_back({1'b1, 1'b0, 8'hA5});
    drive_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (48) @(negedge clk);
    wait_drain(1, "ferr_a5");
    drv_rxd = 1'b1;
    repeat (32) @(negedge clk);

    // Glitch rejection, then a clean 0x3C frame
    drv_rxd = 1'b0;
    repeat (4) @(negedge clk);
    drv_rxd = 1'b1;
    repeat (40) @(negedge clk);
    exp_q1.push_back({1'b0, 1'b0, 8'h3C});
    drive_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    wait_drain(1, "glitch_3c");
    sel1 = 1'b0;
    repeat (20) @(negedge clk);

    // Back-to-back with tx_start held
    exp_q1.push_back({1'b0, 1'b0, 8'h11});
    exp_q1.push_back({1'b0, 1'b0, 8'h22});
    tx_start1 = 1'b1; tx_data1 = 8'h11;
    @(negedge clk);
    check("b2b_busy_rise", 32'(tx_busy1), 32'd1);
    tx_data1 = 8'h22;
    busy_cnt = 0;
    while (tx_busy1 && busy_cnt < 400) begin
      busy_cnt++;
      @(negedge clk);
    end
    check("b2b_first_len", 32'(busy_cnt), 32'd160);
    check("b2b_gap_txd", 32'(txd1), 32'd1);
    @(negedge clk);
    check("b2b_second_busy", 32'(tx_busy1), 32'd1);
    check("b2b_second_start", 32'(txd1), 32'd0);
    tx_start1 = 1'b0;
    repeat (170) @(negedge clk);
    wait_drain(1, "b2b");

`ifdef UART_LOOPBACK_EN
    // Internal loopback: pin stays high, word still received
    loopback1 = 1'b1;
    repeat (4) @(negedge clk);
    exp_q1.push_back({1'b0, 1'b0, 8'h11});
    tx_start1 = 1'b1; tx_data1 = 8'h11;
    @(negedge clk);
    tx_start1 = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 400 && tx_busy1; k++) begin
      if (txd1 != 1'b1) busy_cnt++;
      @(negedge clk);
    end
    check("lb_pin_low_cnt", 32'(busy_cnt), 32'd0);
    check("lb_done", 32'(tx_busy1), 32'd0);
    wait_drain(1, "lb_11");
    loopback1 = 1'b0;
`endif

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
